// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer: FSM state encoding,
// digit width and the per-digit clamp helper.
package bcd_timer_pkg;

  localparam int         BCD_WIDTH = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timerState_t;

  function automatic logic [BCD_WIDTH-1:0] clampDigit(input logic [BCD_WIDTH-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register: load with clamp to 9, decrement on enable+borrow-in,
// wrapping 0 -> 9. Updates one cycle after inputs; no backpressure.
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 loadEn,
  input  logic [BCD_WIDTH-1:0] loadDigit,
  input  logic                 decEn,
  input  logic                 borrowIn,
  output logic [BCD_WIDTH-1:0] digit,
  output logic                 borrowOut,
  output logic                 isZero,
  output logic                 clamped
);

  assign isZero    = (digit == '0);
  assign borrowOut = borrowIn & isZero;
  assign clamped   = (loadDigit > BCD_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= '0;
    end else if (loadEn) begin
      digit <= clampDigit(loadDigit);
    end else if (decEn && borrowIn) begin
      digit <= isZero ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with start/stop/pause, validated load and expiry flags.
// All outputs registered, latency 1 cycle; BCD_TIMER_AUTO_RELOAD_EN enables reload-on-expiry.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BCD_WIDTH*NUM_DIGITS-1:0] load_val,
  input  logic                            load,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            tick,
  output logic [BCD_WIDTH*NUM_DIGITS-1:0] count_out,
  output logic                            running,
  output logic                            done,
  output logic                            done_pulse,
  output logic                            load_err
);

  localparam int W = BCD_WIDTH * NUM_DIGITS;

  timerState_t           state;
  logic [NUM_DIGITS-1:0] zeroVec;
  logic [NUM_DIGITS-1:0] clampVec;
  logic [NUM_DIGITS:0]   borrowChain;
  logic [W-1:0]          cellLoadVal;
  logic                  cellLoadEn;
  logic                  decEn;
  logic                  countZero;
  logic                  countOne;
  logic                  runTick;
  logic                  expiring;
  logic                  reloadNow;

  assign countZero = &zeroVec;
  assign countOne  = (count_out[BCD_WIDTH-1:0] == 4'd1) && (&zeroVec[NUM_DIGITS-1:1]);

  // A tick only counts in RUN when nothing of higher priority claims the cycle.
  assign runTick  = rst && !load && (state == RUN) && !stop && tick;
  assign expiring = runTick && countOne;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0] shadow;
  logic [W-1:0] clampedLoad;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gClamp
    assign clampedLoad[i*BCD_WIDTH +: BCD_WIDTH] = clampDigit(load_val[i*BCD_WIDTH +: BCD_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= clampedLoad;
    end
  end

  assign reloadNow   = expiring && (shadow != '0);
  assign cellLoadVal = load ? load_val : shadow;
`else
  assign reloadNow   = 1'b0;
  assign cellLoadVal = load_val;
`endif

  assign cellLoadEn     = load || reloadNow;
  assign decEn          = runTick && !countZero && !reloadNow;
  assign borrowChain[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
    bcd_digit_cell uCell (
      .clk       (clk),
      .rst       (rst),
      .loadEn    (cellLoadEn),
      .loadDigit (cellLoadVal[i*BCD_WIDTH +: BCD_WIDTH]),
      .decEn     (decEn),
      .borrowIn  (borrowChain[i]),
      .digit     (count_out[i*BCD_WIDTH +: BCD_WIDTH]),
      .borrowOut (borrowChain[i+1]),
      .isZero    (zeroVec[i]),
      .clamped   (clampVec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      load_err   <= 1'b0;
      if (load) begin
        state    <= IDLE;
        running  <= 1'b0;
        done     <= 1'b0;
        load_err <= |clampVec;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              if (countZero) begin
                state      <= EXPIRED;
                done       <= 1'b1;
                done_pulse <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (expiring) begin
              done_pulse <= 1'b1;
              if (!reloadNow) begin
                state   <= EXPIRED;
                running <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (start && !stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (NUM_DIGITS=4).
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] load_val;
  logic        load, start, stop, tick;
  logic [15:0] count_out;
  logic        running, done, done_pulse, load_err;

  int checkCnt = 0;
  int errCnt   = 0;

  bcd_countdown_timer #(.NUM_DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_val   (load_val),
    .load       (load),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .count_out  (count_out),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic step(input logic l, input logic [15:0] lv, input logic s,
                      input logic sp, input logic t);
    load = l; load_val = lv; start = s; stop = sp; tick = t;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = 16'h0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    idle();
    checkVal("rst_count", count_out, 16'h0000);
    checkVal("rst_running", running, 1'b0);
    checkVal("rst_done", done, 1'b0);
    checkVal("rst_done_pulse", done_pulse, 1'b0);
    checkVal("rst_load_err", load_err, 1'b0);
    rst = 1'b1;

    // Borrow across two digits
    step(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    checkVal("load0100", count_out, 16'h0100);
    checkVal("load0100_err", load_err, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkVal("start_running", running, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("tick1_0099", count_out, 16'h0099);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("tick2_0098", count_out, 16'h0098);
    checkVal("tick2_running", running, 1'b1);

    // Expiry
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    checkVal("load2_running", running, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("exp_tick1", count_out, 16'h0001);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    checkVal("reload_count", count_out, 16'h0002);
    checkVal("reload_pulse", done_pulse, 1'b1);
    checkVal("reload_done", done, 1'b0);
    checkVal("reload_running", running, 1'b1);
    idle();
    checkVal("reload_pulse_drop", done_pulse, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("reload_next_tick", count_out, 16'h0001);
`else
    checkVal("exp_count", count_out, 16'h0000);
    checkVal("exp_done", done, 1'b1);
    checkVal("exp_pulse", done_pulse, 1'b1);
    checkVal("exp_running", running, 1'b0);
    idle();
    checkVal("exp_pulse_drop", done_pulse, 1'b0);
    checkVal("exp_done_sticky", done, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    checkVal("exp_hold_count", count_out, 16'h0000);
    checkVal("exp_hold_running", running, 1'b0);
    checkVal("exp_hold_pulse", done_pulse, 1'b0);
`endif

    // Pause drops the coincident tick; resume tick is also dropped
    step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    checkVal("load_clears_done", done, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("p_tick_0009", count_out, 16'h0009);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    checkVal("p_stop_count", count_out, 16'h0009);
    checkVal("p_stop_running", running, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("p_pause_tick", count_out, 16'h0009);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    checkVal("p_resume_count", count_out, 16'h0009);
    checkVal("p_resume_running", running, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("p_tick_0008", count_out, 16'h0008);

    // Clamped load
    step(1'b1, 16'h1A3F, 1'b0, 1'b0, 1'b0);
    checkVal("clamp_count", count_out, 16'h1939);
    checkVal("clamp_err", load_err, 1'b1);
    idle();
    checkVal("clamp_err_drop", load_err, 1'b0);

    // Load wins over start/stop/tick in the same cycle
    step(1'b1, 16'h0042, 1'b1, 1'b0, 1'b1);
    checkVal("load_prio_count", count_out, 16'h0042);
    checkVal("load_prio_running", running, 1'b0);

    // Reset mid-run
    step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("mid_count", count_out, 16'h0002);
    rst = 1'b0;
    idle();
    checkVal("mid_rst_count", count_out, 16'h0000);
    checkVal("mid_rst_running", running, 1'b0);
    checkVal("mid_rst_done", done, 1'b0);
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkVal("idle_tick_count", count_out, 16'h0000);

    // Start with zero count expires immediately
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkVal("zero_start_done", done, 1'b1);
    checkVal("zero_start_pulse", done_pulse, 1'b1);
    checkVal("zero_start_running", running, 1'b0);

    // Start and stop together: stop wins
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    checkVal("ss_idle_running", running, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkVal("ss_start_running", running, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    checkVal("ss_run_running", running, 1'b0);
    checkVal("ss_run_count", count_out, 16'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised N-digit BCD countdown timer; generalises the two-digit cascaded digit timer to NUM_DIGITS digits.
- Adds start/stop/pause control, a full-width parallel load with digit validation, and an explicit FSM.
- Adds a sticky done flag plus a one-cycle expiry pulse.
- Sits between the one-second tick generator and the seven-segment display driver in the lab timer top level.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (legal range 2..8); digit 0 is least significant.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- load_val  input  4*NUM_DIGITS  BCD value to load; digit i at bits [4i+3:4i]
- load  input  1  load strobe; highest priority after reset
- start  input  1  start/resume request (level sampled each cycle)
- stop  input  1  pause request
- tick  input  1  one-cycle pulse, one per second, from the tick generator
- count_out  output  4*NUM_DIGITS  current BCD count
- running  output  1  high while in RUN
- done  output  1  sticky expiry flag
- done_pulse  output  1  one-cycle pulse on expiry
- load_err  output  1  one-cycle pulse; a loaded digit was >9

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
  - Reset (rst==0 at a clk edge) gives count_out=0, running=0, done=0, done_pulse=0, load_err=0, state=IDLE.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. Priority per cycle: reset > load > stop > start > tick.
- Load (any state):
  - count_out <= load_val, with any digit >9 clamped to 9; load_err=1 next cycle if any digit was clamped.
  - done cleared; state -> IDLE; start, stop and tick in the same cycle are ignored.
- IDLE:
  - start with count!=0 -> RUN.
  - start with count==0 -> EXPIRED, done=1, done_pulse=1 next cycle.
- RUN:
  - Each tick decrements count by 1 in BCD; a digit at 0 borrows from the next digit and becomes 9.
  - count_out updates on the edge after tick is sampled (latency 1).
  - tick when count==1 -> count 0, state EXPIRED, done=1 and done_pulse=1 on the same edge.
  - stop -> PAUSE; a tick in the same cycle is dropped.
- PAUSE: count holds and ticks are ignored; start -> RUN; the first decrement happens on the next tick after the cycle start is sampled.
- Start edge case: start and tick in the same cycle from IDLE/PAUSE -> the tick is ignored.
- EXPIRED: count holds at 0; start, stop and tick are ignored; done holds until load or reset.
- Simultaneous start and stop: stop wins (RUN -> PAUSE, IDLE/PAUSE unchanged).
- running = (state==RUN), registered.
- done_pulse and load_err are never high for more than one consecutive cycle unless retriggered.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - A shadow register captures the clamped value on each load; reset clears it to 0.
  - In RUN, a tick at count==1 loads count_out <= shadow, pulses done_pulse, leaves done=0 and stays in RUN.
  - If the shadow is 0, behaviour is the same as without the feature.
- Undefined: no shadow register; expiry always enters EXPIRED as described above.

Decomposition:
- Shared package bcd_timer_pkg:
  - FSM state enumeration: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3.
  - Constants BCD_MAX=4'd9 and BCD_WIDTH=4.
- Sub-module bcd_digit_cell:
  - One 4-bit digit with load, clamp, and decrement-enable inputs.
  - Borrow-in/borrow-out outputs; zero flag output.
  - Instantiated NUM_DIGITS times via generate, borrow chained from LSD to MSD.
- Top level holds the FSM, the all-zero/equals-one detect, and the optional shadow register.

Test Plan:
- NUM_DIGITS=4:
  - Reset, load 0x0100, start, 1 tick -> count_out=0x0099.
  - Second tick -> 0x0098; running=1.
- Load 0x0002, start, 2 ticks -> after 2nd tick count_out=0x0000, done=1, done_pulse high exactly 1 cycle, state EXPIRED; further ticks and start leave count at 0.
- Load 0x0010, start, 1 tick, stop+tick same cycle -> count_out stays 0x0009; start, 1 tick -> 0x0008.
- Load 0x1A3F -> count_out=0x1939, load_err pulses 1 cycle.
- Load 0x0005, start, 3 ticks, assert rst=0 mid-run -> all outputs 0 and state IDLE on the next edge.
- With BCD_TIMER_AUTO_RELOAD_EN:
  - Load 0x0002, start, 2 ticks -> count_out=0x0002, done_pulse=1, done=0, running=1.
  - Without the macro, the same stimulus -> count_out=0x0000, done=1.
